// File: rtl/mips_pkg.sv
// Purpose : shared MIPS encodings, instruction field positions and the fetch/decode FSM state type.
// Latency : n/a (declarations only).
// Backpressure : n/a.
package mips_pkg;

  // Opcode and funct encodings
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_HALT   = 6'h3F;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Bit positions of the instruction fields
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;
  localparam int SH_MSB = 10;
  localparam int SH_LSB = 6;
  localparam int FN_MSB = 5;
  localparam int FN_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fd_state_t;

endpackage

// File: rtl/imem_rom_rw.sv
// Purpose : DEPTH x 32 instruction array, written synchronously, read combinationally.
// Latency : write visible to the read port on the cycle after the write edge; read is 0 cycles.
// Backpressure : none; the caller gates the write enable.
// Ports   : clk; we/waddr/wdata write port; raddr -> rdata read port.
module imem_rom_rw #(
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  // Contents deliberately survive reset so a program can be loaded once.
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/r_type_fetch_decode.sv
// Purpose : PC + instruction memory; fetches one word per cycle and presents decoded R-type fields.
// Latency : first valid one cycle after the start edge; one instruction per cycle while out_ready=1.
// Backpressure : out_valid/out_ready; outputs and PC freeze in HOLD, one bubble after HOLD releases.
// Ports   : clk, rst (sync, active-high); imem_we/imem_waddr/imem_wdata load port (IDLE only);
//           start; out_ready/out_valid handshake with rs, rt, rd, shamt, funct, pc_out;
//           illegal pulse, halted level, illegal_count (saturating at 255).
module r_type_fetch_decode
  import mips_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFC00_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          start,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [4:0]                    rs,
  output logic [4:0]                    rt,
  output logic [4:0]                    rd,
  output logic [4:0]                    shamt,
  output logic [5:0]                    funct,
  output logic [31:0]                   pc_out,
  output logic                          illegal,
  output logic                          halted,
  output logic [7:0]                    illegal_count
);

  localparam int AW = $clog2(IMEM_DEPTH);

  fd_state_t   state;
  logic [31:0] pc;
  logic [31:0] word;
  logic        mem_we;

  // Loading is only allowed while nothing is being fetched.
  assign mem_we = imem_we && (state == ST_IDLE);

  // Word index taken straight from the byte PC, so fetch wraps modulo IMEM_DEPTH.
  imem_rom_rw #(.DEPTH(IMEM_DEPTH)) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .raddr (pc[AW+1:2]),
    .rdata (word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      out_valid     <= 1'b0;
      illegal       <= 1'b0;
      halted        <= 1'b0;
      illegal_count <= 8'd0;
      rs            <= 5'd0;
      rt            <= 5'd0;
      rd            <= 5'd0;
      shamt         <= 5'd0;
      funct         <= 6'd0;
      pc_out        <= 32'd0;
    end else begin
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state         <= ST_RUN;
            pc            <= RESET_PC;
            illegal_count <= 8'd0;
          end
        end

        ST_RUN: begin
          if (out_valid && !out_ready) begin
            // Presented word not yet taken: freeze rather than overwrite it.
            state <= ST_HOLD;
          end else if (word == HALT_WORD) begin
            state     <= ST_HALT;
            out_valid <= 1'b0;
            halted    <= 1'b1;
          end else if (word[OP_MSB:OP_LSB] != OP_RTYPE) begin
            illegal   <= 1'b1;
            out_valid <= 1'b0;
            pc        <= pc + 32'd4;
            if (illegal_count != 8'hFF) begin
              illegal_count <= illegal_count + 8'd1;
            end
          end else begin
            rs        <= word[RS_MSB:RS_LSB];
            rt        <= word[RT_MSB:RT_LSB];
            rd        <= word[RD_MSB:RD_LSB];
            shamt     <= word[SH_MSB:SH_LSB];
            funct     <= word[FN_MSB:FN_LSB];
            pc_out    <= pc;
            out_valid <= 1'b1;
            pc        <= pc + 32'd4;
            if (!out_ready) begin
              state <= ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          // The transfer happens on this edge; the next fetch lands one edge later.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_RUN;
          end
        end

        ST_HALT: begin
          if (start) begin
            state         <= ST_RUN;
            pc            <= RESET_PC;
            illegal_count <= 8'd0;
            halted        <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
